// File: rtl/iiravg_mc.sv
// iiravg_mc -- time-multiplexed, multi-channel, single-pole recursive averager.
//
//   avg[c] <= avg[c] + ((x - avg[c]) >>> lgalpha)
//
// One subtract/shift/add datapath serves NCHAN channels whose averages live
// in a small state RAM. Each input sample is left-justified into AW bits, so
// there are MAXLG fractional guard bits below the output LSB. The first sample
// of a channel, or any sample with lgalpha == 0, loads the average directly.
// Latency is fixed at 2 cycles. Back-to-back samples on one channel are handled
// by forwarding the stage-2 result into stage 1.
//
// Ports:
//   i_clk      clock
//   i_reset    synchronous, active-high reset
//   i_valid    input sample strobe (at most one sample per cycle)
//   i_chan     channel index of i_data
//   i_data     signed input sample
//   i_lgalpha  smoothing shift, sampled with i_valid, clamped to MAXLG
//   o_valid    output strobe, 2 cycles after i_valid
//   o_chan     channel of o_data
//   o_data     updated average, top OW bits of the accumulator
module iiravg_mc #(
  parameter  int IW    = 16,
  parameter  int OW    = 16,
  parameter  int NCHAN = 4,
  parameter  int MAXLG = 8,
  localparam int LGCH  = $clog2(NCHAN),
  localparam int AW    = ((IW > OW) ? IW : OW) + MAXLG,
  localparam int LGW   = $clog2(MAXLG + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [LGCH-1:0]        i_chan,
  input  logic signed [IW-1:0]   i_data,
  input  logic [LGW-1:0]         i_lgalpha,
  output logic                   o_valid,
  output logic [LGCH-1:0]        o_chan,
  output logic signed [OW-1:0]   o_data
);

  // Per-channel state
  logic signed [AW-1:0] avg_mem [NCHAN];
  logic [NCHAN-1:0]     primed_q;

  // Stage 1 registers
  logic                 s1_valid_q;
  logic signed [AW-1:0] s1_xa_q, s1_avg_q;
  logic [LGCH-1:0]      s1_chan_q;
  logic [LGW-1:0]       s1_lg_q;
  logic                 s1_primed_q;

  // Stage 1 next-state values
  logic signed [AW-1:0] s1_xa_d, s1_avg_d;
  logic [LGW-1:0]       s1_lg_d;
  logic                 s1_primed_d;
  logic                 fwd;

  // Stage 2 datapath
  logic signed [AW:0]   diff, adj;
  logic signed [AW-1:0] new_avg;
  logic                 unused_adj_msb;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1_xa_d     = {i_data, {(AW-IW){1'b0}}};
    s1_lg_d     = (i_lgalpha > LGW'(MAXLG)) ? LGW'(MAXLG) : i_lgalpha;
    // The older same-channel sample is writing the RAM on this very edge, so
    // its result (and its primed bit) must bypass the stale RAM contents.
    fwd         = s1_valid_q && (s1_chan_q == i_chan);
    s1_avg_d    = fwd ? new_avg : avg_mem[i_chan];
    s1_primed_d = fwd ? 1'b1    : primed_q[i_chan];
  end

  always_comb begin
    // Sign-extended by one bit: the difference of two AW-bit values always fits.
    diff    = {s1_xa_q[AW-1], s1_xa_q} - {s1_avg_q[AW-1], s1_avg_q};
    adj     = diff >>> s1_lg_q;
    // |adj| <= |diff| and adj has the sign of diff, so the sum stays between
    // the old average and xa and cannot overflow AW bits.
    new_avg = s1_avg_q + adj[AW-1:0];
    if (!s1_primed_q || (s1_lg_q == '0)) begin
      new_avg = s1_xa_q;
    end
  end

  assign unused_adj_msb = adj[AW];

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (i_reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= i_valid;
    end
    if (i_valid) begin
      s1_xa_q     <= s1_xa_d;
      s1_avg_q    <= s1_avg_d;
      s1_chan_q   <= i_chan;
      s1_lg_q     <= s1_lg_d;
      s1_primed_q <= s1_primed_d;
    end
  end

  // NOTE: the average RAM is deliberately not reset; the cleared primed bits make stale contents unobservable.
  always_ff @(posedge i_clk) begin
    if (s1_valid_q && !i_reset) begin
      avg_mem[s1_chan_q] <= new_avg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      primed_q <= '0;
    end else if (s1_valid_q) begin
      primed_q[s1_chan_q] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_chan  <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= s1_valid_q;
      if (s1_valid_q) begin
        o_chan <= s1_chan_q;
        o_data <= new_avg[AW-1 -: OW];
      end
    end
  end

endmodule
